// File: rtl/kv10_div_seq.sv
// kv10_div_seq: start/done divide sequencer that steps an external combinational ALU through DIV/IDIV.
// Define KV10_DIV_IDIV_EN to build IDIV (36/36) support; otherwise every operation is a 72/36 DIV.
`ifndef WORD
`define WORD 36
`endif
`ifndef aluCMDwidth
`define aluCMDwidth 6
`endif
`ifndef aluSETA
`define aluSETA 6'd1
`endif
`ifndef aluDIV_MAG72
`define aluDIV_MAG72 6'd20
`endif
`ifndef aluDIV_MAG36
`define aluDIV_MAG36 6'd21
`endif
`ifndef aluDIV_OP
`define aluDIV_OP 6'd22
`endif
`ifndef aluDIV_FIXR
`define aluDIV_FIXR 6'd23
`endif
`ifndef aluDIV_FIXUP
`define aluDIV_FIXUP 6'd24
`endif

module kv10_div_seq (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     is_idiv,
    input  logic [0:`WORD-1]         dividend_hi,
    input  logic [0:`WORD-1]         dividend_lo,
    input  logic [0:`WORD-1]         divisor,
    output logic                     busy,
    output logic                     done,
    output logic                     no_divide,
    output logic [0:`WORD-1]         quotient,
    output logic [0:`WORD-1]         remainder,
    output logic [`aluCMDwidth-1:0]  alu_cmd,
    output logic [0:`WORD-1]         alu_A,
    output logic [0:`WORD-1]         alu_Alow,
    output logic [0:`WORD-1]         alu_M,
    output logic                     alu_div_neg,
    input  logic [0:`WORD-1]         alu_result,
    input  logic [0:`WORD-1]         alu_resultlow,
    input  logic                     alu_overflow
);

    typedef enum logic [2:0] {StIdle, StMag, StStep, StFixr, StFixup, StDone} state_e;

    state_e           state_q, state_d;
    logic [0:`WORD-1] r_q, r_d, q_q, q_d, d_q, d_d;
    logic [0:`WORD-1] quo_q, quo_d, rem_q, rem_d;
    logic [5:0]       k_q, k_d;
    logic             n_q, n_d;
    logic             busy_q, busy_d, done_q, done_d, nd_q, nd_d;

`ifdef KV10_DIV_IDIV_EN
    localparam logic [0:`WORD-1] MostNeg = {1'b1, {(`WORD-1){1'b0}}};
    logic idiv_q, idiv_d;
`else
    logic unused_is_idiv;
    assign unused_is_idiv = is_idiv;
`endif

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        q_d      = q_q;
        d_d      = d_q;
        k_d      = k_q;
        n_d      = n_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        nd_d     = nd_q;
`ifdef KV10_DIV_IDIV_EN
        idiv_d   = idiv_q;
`endif
        alu_cmd  = `aluSETA;
        alu_A    = r_q;
        alu_Alow = q_q;
        alu_M    = d_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    d_d     = divisor;
                    r_d     = dividend_hi;
                    q_d     = dividend_lo;
                    k_d     = 6'd0;
                    nd_d    = 1'b0;
                    state_d = StMag;
`ifdef KV10_DIV_IDIV_EN
                    idiv_d  = is_idiv;
                    n_d     = is_idiv ? dividend_lo[0] : dividend_hi[0];
                    // Most-negative / -1 overflows the quotient; the step sequence would not catch it.
                    if (is_idiv && dividend_lo == MostNeg && divisor == '1) begin
                        nd_d    = 1'b1;
                        state_d = StDone;
                    end
`else
                    n_d     = dividend_hi[0];
`endif
                end
            end
            StMag: begin
                alu_cmd = `aluDIV_MAG72;
`ifdef KV10_DIV_IDIV_EN
                if (idiv_q) begin
                    alu_cmd = `aluDIV_MAG36;
                    alu_A   = q_q;
                end
`endif
                r_d     = alu_result;
                q_d     = alu_resultlow;
                state_d = StStep;
            end
            StStep: begin
                alu_cmd = `aluDIV_OP;
                // A set first quotient bit means the quotient cannot fit (includes divisor 0).
                if (k_q == 6'd0 && alu_overflow) begin
                    nd_d    = 1'b1;
                    state_d = StDone;
                end else begin
                    r_d = alu_result;
                    q_d = alu_resultlow;
                    k_d = k_q + 6'd1;
                    if (k_q == 6'd35) state_d = StFixr;
                end
            end
            StFixr: begin
                alu_cmd = `aluDIV_FIXR;
                r_d     = alu_result;
                q_d     = alu_resultlow;
                state_d = StFixup;
            end
            StFixup: begin
                alu_cmd = `aluDIV_FIXUP;
                quo_d   = alu_result;
                rem_d   = alu_resultlow;
                state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StMag) || (state_d == StStep) || (state_d == StFixr) ||
                 (state_d == StFixup);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            k_q     <= '0;
            n_q     <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            nd_q    <= 1'b0;
`ifdef KV10_DIV_IDIV_EN
            idiv_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            k_q     <= k_d;
            n_q     <= n_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            nd_q    <= nd_d;
`ifdef KV10_DIV_IDIV_EN
            idiv_q  <= idiv_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign no_divide   = nd_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign alu_div_neg = n_q;

endmodule

// File: tb/tb_kv10_div_seq.sv
// Bench for kv10_div_seq: behavioural restoring-divide ALU plus a scoreboard of expected results.
// IDIV vectors run only when KV10_DIV_IDIV_EN is defined.
`ifndef WORD
`define WORD 36
`endif
`ifndef aluCMDwidth
`define aluCMDwidth 6
`endif
`ifndef aluSETA
`define aluSETA 6'd1
`endif
`ifndef aluDIV_MAG72
`define aluDIV_MAG72 6'd20
`endif
`ifndef aluDIV_MAG36
`define aluDIV_MAG36 6'd21
`endif
`ifndef aluDIV_OP
`define aluDIV_OP 6'd22
`endif
`ifndef aluDIV_FIXR
`define aluDIV_FIXR 6'd23
`endif
`ifndef aluDIV_FIXUP
`define aluDIV_FIXUP 6'd24
`endif

module tb_kv10_div_seq;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    start = 1'b0;
    logic                    is_idiv = 1'b0;
    logic [0:35]             dividend_hi = '0, dividend_lo = '0, divisor = '0;
    logic                    busy, done, no_divide;
    logic [0:35]             quotient, remainder;
    logic [`aluCMDwidth-1:0] alu_cmd;
    logic [0:35]             alu_A, alu_Alow, alu_M;
    logic                    alu_div_neg;
    logic [0:35]             alu_result, alu_resultlow;
    logic                    alu_overflow;

    kv10_div_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .is_idiv(is_idiv),
        .dividend_hi(dividend_hi), .dividend_lo(dividend_lo), .divisor(divisor),
        .busy(busy), .done(done), .no_divide(no_divide),
        .quotient(quotient), .remainder(remainder),
        .alu_cmd(alu_cmd), .alu_A(alu_A), .alu_Alow(alu_Alow), .alu_M(alu_M),
        .alu_div_neg(alu_div_neg), .alu_result(alu_result), .alu_resultlow(alu_resultlow),
        .alu_overflow(alu_overflow)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    // Restoring-divide ALU: MAG yields |dividend| split as R/Q, each OP step shifts R,Q left
    // and subtracts |M| when it fits, FIXR passes through, FIXUP applies the signs.
    logic [70:0] x71, m71;
    logic [35:0] a36, m36, dm, q36, r36;
    logic [36:0] sh, df;
    logic        ovf;
    always_comb begin
        alu_result    = alu_A;
        alu_resultlow = alu_Alow;
        alu_overflow  = 1'b0;
        x71 = {alu_A, alu_Alow[1:35]};
        m71 = x71[70] ? -x71 : x71;
        a36 = alu_A;
        m36 = alu_M;
        dm  = m36[35] ? -m36 : m36;
        sh  = {alu_A, alu_Alow[0]};
        df  = sh - {1'b0, dm};
        ovf = (sh >= {1'b0, dm});
        q36 = alu_Alow;
        r36 = alu_A;
        case (alu_cmd)
            `aluDIV_MAG72: begin
                alu_result    = {1'b0, m71[70:36]};
                alu_resultlow = m71[35:0];
            end
            `aluDIV_MAG36: begin
                alu_result    = '0;
                alu_resultlow = a36[35] ? -a36 : a36;
            end
            `aluDIV_OP: begin
                alu_overflow  = ovf;
                alu_result    = ovf ? df[35:0] : sh[35:0];
                alu_resultlow = {alu_Alow[1:35], ovf};
            end
            `aluDIV_FIXUP: begin
                alu_result    = (alu_div_neg ^ m36[35]) ? -q36 : q36;
                alu_resultlow = alu_div_neg ? -r36 : r36;
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [35:0] quo;
        logic [35:0] rem;
        logic        nd;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    logic [35:0] last_quo = '0, last_rem = '0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected result from plain signed arithmetic on the operands.
    task automatic push_exp(input logic [35:0] hi, input logic [35:0] lo, input logic [35:0] dv,
                            input bit idiv, input bit nd, input int cyc);
        exp_t e;
        logic signed [71:0] a, b, qq, rr;
        if (idiv) a = {{36{lo[35]}}, lo};
        else      a = {hi[35], hi, lo[34:0]};
        b = {{36{dv[35]}}, dv};
        if (!nd) begin
            qq = a / b;
            rr = a % b;
            last_quo = qq[35:0];
            last_rem = rr[35:0];
        end
        e.quo = last_quo;
        e.rem = last_rem;
        e.nd  = nd;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic run_op(input string tag, input logic [35:0] hi, input logic [35:0] lo,
                          input logic [35:0] dv, input bit pin_idiv, input bit model_idiv,
                          input bit exp_nd, input int exp_cyc, input bit mid_pulse,
                          output int start_edge, output int done_edge);
        int   cyc;
        exp_t e;
        dividend_hi = hi;
        dividend_lo = lo;
        divisor     = dv;
        is_idiv     = pin_idiv;
        start       = 1'b1;
        push_exp(hi, lo, dv, model_idiv, exp_nd, exp_cyc);
        @(posedge clk);
        #1;
        start_edge = edges;
        start = 1'b0;
        cyc = 1;
        chk({tag, "_busy_c1"}, 72'(busy), 72'(exp_cyc > 1));
        while (!done && cyc < 100) begin
            if (mid_pulse && cyc == 10) begin
                start   = 1'b1;
                divisor = 36'd1;
            end else if (mid_pulse && cyc == 11) begin
                start   = 1'b0;
                divisor = dv;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        done_edge = edges;
        chk({tag, "_done_cycle"}, 72'(done ? cyc : -1), 72'(exp_cyc));
        chk({tag, "_sb_nonempty"}, 72'(sb.size()), 72'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_no_divide"}, 72'(no_divide), 72'(e.nd));
            chk({tag, "_quotient"}, 72'(quotient), 72'(e.quo));
            chk({tag, "_remainder"}, 72'(remainder), 72'(e.rem));
            chk({tag, "_busy_done"}, 72'(busy), 72'(0));
        end
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 72'(done), 72'(0));
    endtask

    initial begin
        int s0, d0, s1, d1, cnt;
        #2;
        chk("rst_busy", 72'(busy), 72'(0));
        chk("rst_done", 72'(done), 72'(0));
        chk("rst_nodiv", 72'(no_divide), 72'(0));
        chk("rst_quo", 72'(quotient), 72'(0));
        chk("rst_rem", 72'(remainder), 72'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("div_100_7", 36'd0, 36'd100, 36'd7, 1'b0, 1'b0, 1'b0, 40, 1'b0, s0, d0);
        run_op("div_ovf", 36'd5, 36'd0, 36'd3, 1'b0, 1'b0, 1'b1, 3, 1'b0, s0, d0);
        run_op("div_negdvs", 36'd0, 36'd100, -36'sd7, 1'b0, 1'b0, 1'b0, 40, 1'b0, s0, d0);
        run_op("div_neg72", 36'o777777777777, 36'o777777776030, 36'd9, 1'b0, 1'b0, 1'b0, 40,
               1'b0, s0, d0);
        run_op("div_zero", 36'd0, 36'd100, 36'd0, 1'b0, 1'b0, 1'b1, 3, 1'b0, s0, d0);
        run_op("div_mid", 36'd1, 36'd12345, 36'd1000, 1'b0, 1'b0, 1'b0, 40, 1'b1, s0, d0);
        run_op("div_b2b", 36'd0, 36'd999, 36'd10, 1'b0, 1'b0, 1'b0, 40, 1'b0, s1, d1);
        chk("b2b_cycle", 72'(d1 - s0 + 1), 72'(81));
`ifdef KV10_DIV_IDIV_EN
        run_op("idiv_m100_7", 36'd0, 36'o777777777634, 36'd7, 1'b1, 1'b1, 1'b0, 40, 1'b0,
               s0, d0);
        chk("idiv_q_const", 72'(quotient), 72'(36'o777777777762));
        run_op("idiv_zero", 36'd0, 36'd100, 36'd0, 1'b1, 1'b1, 1'b1, 3, 1'b0, s0, d0);
        run_op("idiv_minneg", 36'd0, 36'o400000000000, 36'o777777777777, 1'b1, 1'b1, 1'b1, 1,
               1'b0, s0, d0);
`else
        run_op("idiv_ignored", 36'd0, 36'o400000000000, 36'o777777777777, 1'b1, 1'b0, 1'b0,
               40, 1'b0, s0, d0);
`endif

        // Asynchronous reset in cycle 20 of a DIV.
        run_op("pre_rst", 36'd0, 36'd100, 36'd7, 1'b0, 1'b0, 1'b0, 40, 1'b0, s0, d0);
        dividend_hi = 36'd0;
        dividend_lo = 36'd200;
        divisor     = 36'd3;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 72'(busy), 72'(0));
        chk("arst_done", 72'(done), 72'(0));
        chk("arst_nodiv", 72'(no_divide), 72'(0));
        chk("arst_quo", 72'(quotient), 72'(0));
        chk("arst_rem", 72'(remainder), 72'(0));
        last_quo = '0;
        last_rem = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cnt = 0;
        repeat (45) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
        chk("arst_no_done", 72'(cnt), 72'(0));
        run_op("post_rst", 36'd0, 36'd200, 36'd3, 1'b0, 1'b0, 1'b0, 40, 1'b0, s0, d0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kv10_div_seq.md
# kv10_div_seq

Multi-cycle divide sequencer for the kv10 datapath. It issues the ALU's division command sequence (`aluDIV_MAG72`/`aluDIV_MAG36`, `aluDIV_OP`, `aluDIV_FIXR`, `aluDIV_FIXUP`) to a separately instantiated `alu` and holds the partial remainder, quotient and divisor between steps. It returns the signed quotient and remainder for DIV (72/36) and IDIV (36/36), or flags no-divide. The instruction engine treats it as a start/done coprocessor.

## Interface

Parameters:
- none. Widths come from `WORD` and `aluCMDwidth`.

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin an operation; honoured only in IDLE
- `is_idiv`  in  1  1 = IDIV (dividend is `dividend_lo` only), 0 = DIV (72-bit `dividend_hi`,,`dividend_lo`, bit 0 of `dividend_lo` ignored)
- `dividend_hi`  in  36  high dividend word
- `dividend_lo`  in  36  low dividend word
- `divisor`  in  36  divisor
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `done`  out  1  one-cycle completion pulse
- `no_divide`  out  1  valid with `done`; held until the next `start`
- `quotient`  out  36  signed quotient; held until the next successful completion
- `remainder`  out  36  signed remainder; sign follows the dividend
- `alu_cmd`  out  `aluCMDwidth`  command to the ALU
- `alu_A`, `alu_Alow`, `alu_M`  out  36 each  ALU operands
- `alu_div_neg`  out  1  sign of the original dividend
- `alu_result`, `alu_resultlow`  in  36 each  ALU outputs
- `alu_overflow`  in  1  ALU overflow (quotient bit in `aluDIV_OP`)

## Operation

- Registers: R (remainder/high), Q (quotient/low), D (divisor), N (dividend sign), 6-bit step counter K.
- States: IDLE, MAG, STEP, FIXR, FIXUP, DONE.
- IDLE: `alu_cmd`=`aluSETA`, with all operands driven from R/Q/D.
  - On `start`, latch D=`divisor`, R=`dividend_hi`, Q=`dividend_lo`, N=(is_idiv ? `dividend_lo[0]` : `dividend_hi[0]`), K=0, then go to MAG.
  - If the operation is IDIV with `dividend_lo`=0o400000_000000 and `divisor`=0o777777_777777, set a pending no-divide and go to DONE instead.
- MAG: issue `aluDIV_MAG72` (DIV, A=R, Alow=Q) or `aluDIV_MAG36` (IDIV, A=Q). Latch R=`alu_result`, Q=`alu_resultlow`. Go to STEP.
- STEP: issue `aluDIV_OP` with A=R, Alow=Q, M=D. Latch R and Q each cycle and increment K.
  - If K=0 and `alu_overflow`=1, set no-divide, do not latch R/Q, and go to DONE. This covers divisor 0.
  - After K=35 (36 steps total), go to FIXR.
- FIXR: issue `aluDIV_FIXR`. Latch R and Q. Go to FIXUP.
- FIXUP: issue `aluDIV_FIXUP` with A=R, Alow=Q, M=D. Latch `quotient`=`alu_result` and `remainder`=`alu_resultlow`. Go to DONE.
- DONE: `done`=1 and `busy`=0. Update `no_divide`. Return to IDLE.
- `alu_div_neg`=N in every state.
- `start` while not in IDLE is ignored, with no effect on state or registers.

## Timing

- Reset values: all registers 0, state IDLE, `busy`/`done`/`no_divide`=0, `quotient`/`remainder`=0.
- Reset is asynchronous at any point, including mid-operation. The sequencer returns to IDLE with those values, and no `done` is generated for the aborted operation.
- All ALU inputs are registered and stable for the whole cycle; the ALU is combinational. Every state latches its result at the cycle's end.
- `start` is sampled at edge 0. The sequencer is in MAG in cycle 1, STEP in cycles 2–37, FIXR in cycle 38, FIXUP in cycle 39, and `done` is high in cycle 40.
- No-divide detected in STEP K=0: `done` in cycle 3.
- IDIV most-negative/−1 case: `done` in cycle 1.
- A new `start` is accepted in the cycle after `done`, i.e. back-to-back every 41 cycles.

## Configuration

- `KV10_DIV_IDIV_EN`
  - Defined: full DIV and IDIV support as described above.
  - Undefined: `is_idiv` is ignored and every operation is a 72/36 DIV. The MAG36 path and the most-negative/−1 detector are not built.

## Test plan

- DIV, hi=0, lo=0o000000_000144, divisor=7 -> `done` in cycle 40, Q=0o16, R=2, `no_divide`=0.
- DIV, hi=5, lo=0, divisor=3 -> `done` in cycle 3, `no_divide`=1, `quotient`/`remainder` keep their previous values.
- IDIV (macro on), lo=0o777777_777634 (−100), divisor=7 -> Q=0o777777_777762 (−14), R=0o777777_777776 (−2).
- IDIV, lo=0o000000_000144, divisor=0 -> `no_divide`=1 in cycle 3. IDIV, lo=0o400000_000000, divisor=0o777777_777777 -> `no_divide`=1 in cycle 1.
- Pulse `start` again at cycle 10 during a DIV -> it is ignored and the original result completes at cycle 40. Immediately restart -> second result at cycle 81.
- Assert `reset_n`=0 at cycle 20 mid-DIV -> same cycle `busy`=0 and all outputs 0, no `done`. Then a fresh DIV completes normally.
